// File: rtl/value_report_pkg.sv
// value_report_pkg: shared constants and FSM state type for the value report path
package value_report_pkg;
  localparam int VAL_W = 28;
  localparam int VALID_BIT = 0;
  localparam int OVF_BIT = 1;
  localparam int SEQ_LSB = 2;
  localparam int VAL_LSB = 4;
  typedef enum logic [1:0] {IDLE, SHOW, RELEASE} state_t;
endpackage

// File: rtl/value_report_if.sv
// value_report_if: fabric value strobe, software ack and GPIO readback bundle
interface value_report_if import value_report_pkg::*; #(parameter int DEPTH = 4);
  logic [VAL_W-1:0] val_i;
  logic val_valid_i;
  logic gpio_ack_i;
  logic [31:0] gpio_out;
  logic full_o;
  logic [$clog2(DEPTH+1)-1:0] fifo_count_o;
  modport master (output val_i, val_valid_i, gpio_ack_i, input gpio_out, full_o, fifo_count_o);
  modport slave (input val_i, val_valid_i, gpio_ack_i, output gpio_out, full_o, fifo_count_o);
endinterface

// File: rtl/value_report_fifo.sv
// value_report_fifo: synchronous FIFO with wrap-bit pointers; caller guarantees no push when full without pop
module value_report_fifo import value_report_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [VAL_W-1:0] din,
  output logic [VAL_W-1:0] dout,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  logic [AW:0] wp, rp;
  logic [VAL_W-1:0] mem [DEPTH];
  // pointers advance per accepted push/pop; reset flushes by realigning them
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  // storage needs no reset since the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = CW'(wp - rp);
endmodule

// File: rtl/value_report.sv
// value_report: queues fabric values and presents them as GPIO words under a valid/ack handshake; VALUE_REPORT_SEQ_EN adds a 2-bit sequence tag
module value_report import value_report_pkg::*; #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  value_report_if.slave bus
);
  state_t state, state_nx;
  logic load, show, push, drop, full, empty, ovf_pending, ovf_q;
  logic [VAL_W-1:0] head, val_q;
  value_report_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(load),
    .din(bus.val_i),
    .dout(head),
    .count(bus.fifo_count_o),
    .full(full),
    .empty(empty)
  );
  assign push = bus.val_valid_i && (!full || load);
  assign drop = bus.val_valid_i && full && !load;
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nx;
  end
  // next state: load moves to SHOW, ack rise to RELEASE, ack fall back to IDLE
  always_comb begin
    state_nx = (state == IDLE && load) ? SHOW :
               (state == SHOW && bus.gpio_ack_i) ? RELEASE :
               (state == RELEASE && !bus.gpio_ack_i) ? IDLE : state;
  end
  // FSM outputs: pop the head only in IDLE once software has released ack
  always_comb begin
    load = state == IDLE && !empty && !bus.gpio_ack_i;
    show = state == SHOW;
  end
  // a drop in the load cycle must survive the handoff into the word
  always_ff @(posedge clk) begin
    ovf_pending <= !rst && (drop || (ovf_pending && !load));
  end
  // word fields change only on a load so software sees them stable while valid
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      val_q <= head;
      ovf_q <= ovf_pending;
    end
  end
`ifdef VALUE_REPORT_SEQ_EN
  logic [1:0] seq, tag_q;
  // tag counter steps on each load; the loaded word carries the pre-increment value
  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
      tag_q <= '0;
    end else if (load) begin
      seq <= seq + 1'b1;
      tag_q <= seq;
    end
  end
`else
  logic [1:0] tag_q;
  assign tag_q = '0;
`endif
  // readback word assembly
  always_comb begin
    bus.gpio_out = '0;
    bus.gpio_out[VALID_BIT] = show;
    bus.gpio_out[OVF_BIT] = ovf_q;
    bus.gpio_out[SEQ_LSB +: 2] = tag_q;
    bus.gpio_out[VAL_LSB +: VAL_W] = val_q;
  end
  assign bus.full_o = full;
endmodule

// File: tb/tb_value_report.sv
// tb_value_report: vector table plus scoreboard queue checking of value_report
module tb_value_report;
  import value_report_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [27:0] v;
    logic [31:0] word;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [1:0] seq_m = 2'd0;
  logic [31:0] exp_q[$];
  vec_t vecs[4];
  value_report_if #(.DEPTH(DEPTH)) bus ();
  value_report #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [27:0] v, input bit kept, input bit ovf);
    bus.val_i = v;
    bus.val_valid_i = 1'b1;
    if (kept) exp_q.push_back({v, 2'b00, ovf, 1'b1});
    tick();
    bus.val_valid_i = 1'b0;
  endtask

  task automatic take_word();
    int n = 0;
    logic [31:0] e, w;
    while (!bus.gpio_out[0] && n < 20) begin
      tick();
      n++;
    end
    chk("present", 32'(bus.gpio_out[0]), 32'd1);
    e = (exp_q.size() == 0) ? 32'h0 : exp_q.pop_front();
`ifdef VALUE_REPORT_SEQ_EN
    e[3:2] = seq_m;
    seq_m = seq_m + 2'd1;
`endif
    chk("word", bus.gpio_out, e);
    w = bus.gpio_out;
    bus.gpio_ack_i = 1'b1;
    tick();
    chk("ack_clear", bus.gpio_out, {w[31:1], 1'b0});
    bus.gpio_ack_i = 1'b0;
    tick();
    chk("release_idle", 32'(bus.gpio_out[0]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{28'hABCDEF0, 32'hABCDEF01};
    vecs[1] = '{28'h0000000, 32'h00000001};
    vecs[2] = '{28'hFFFFFFF, 32'hFFFFFFF1};
    vecs[3] = '{28'h1234567, 32'h12345671};
    rst = 1'b1;
    bus.val_i = '0;
    bus.val_valid_i = 1'b0;
    bus.gpio_ack_i = 1'b0;
    tick();
    tick();
    chk("rst_out", bus.gpio_out, 32'h0);
    chk("rst_count", 32'(bus.fifo_count_o), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    rst = 1'b0;
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].word);
      bus.val_i = vecs[i].v;
      bus.val_valid_i = 1'b1;
      tick();
      bus.val_valid_i = 1'b0;
      chk("vec_count1", 32'(bus.fifo_count_o), 32'd1);
      chk("vec_preload", 32'(bus.gpio_out[0]), 32'd0);
      tick();
      chk("vec_load_lat", 32'(bus.gpio_out[0]), 32'd1);
      chk("vec_count0", 32'(bus.fifo_count_o), 32'd0);
      take_word();
    end
    bus.gpio_ack_i = 1'b1;
    strobe(28'h5A5A5A5, 1'b1, 1'b0);
    repeat (3) tick();
    chk("ackhi_noload", 32'(bus.gpio_out[0]), 32'd0);
    chk("ackhi_count", 32'(bus.fifo_count_o), 32'd1);
    bus.gpio_ack_i = 1'b0;
    tick();
    chk("ackhi_release", 32'(bus.gpio_out[0]), 32'd1);
    take_word();
    for (int i = 0; i < 5; i++) strobe(28'(32'h100 + i), 1'b1, 1'b0);
    chk("burst_full", 32'(bus.full_o), 32'd1);
    chk("burst_count", 32'(bus.fifo_count_o), 32'd4);
    repeat (5) take_word();
    chk("burst_drained", 32'(bus.fifo_count_o), 32'd0);
    chk("burst_sb_empty", 32'(exp_q.size()), 32'd0);
    strobe(28'h200, 1'b1, 1'b0);
    strobe(28'h201, 1'b1, 1'b1);
    strobe(28'h202, 1'b1, 1'b0);
    strobe(28'h203, 1'b1, 1'b0);
    strobe(28'h204, 1'b1, 1'b0);
    strobe(28'h2FF, 1'b0, 1'b0);
    chk("ovf_count", 32'(bus.fifo_count_o), 32'd4);
    chk("ovf_full", 32'(bus.full_o), 32'd1);
    take_word();
    strobe(28'h3AA, 1'b1, 1'b0);
    chk("pushpop_count", 32'(bus.fifo_count_o), 32'd4);
    chk("pushpop_full", 32'(bus.full_o), 32'd1);
    chk("pushpop_show", 32'(bus.gpio_out[0]), 32'd1);
    repeat (5) take_word();
    chk("ovf_drained", 32'(bus.fifo_count_o), 32'd0);
    chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
    strobe(28'h400, 1'b0, 1'b0);
    tick();
    chk("rst_pre_show", 32'(bus.gpio_out[0]), 32'd1);
    for (int i = 1; i < 6; i++) strobe(28'(32'h400 + i), 1'b0, 1'b0);
    chk("rst_pre_count", 32'(bus.fifo_count_o), 32'd4);
    rst = 1'b1;
    bus.val_i = 28'h7FF;
    bus.val_valid_i = 1'b1;
    tick();
    chk("rst_show_out", bus.gpio_out, 32'h0);
    chk("rst_show_count", 32'(bus.fifo_count_o), 32'd0);
    chk("rst_show_full", 32'(bus.full_o), 32'd0);
    tick();
    chk("rst_ignore_strobe", 32'(bus.fifo_count_o), 32'd0);
    bus.val_valid_i = 1'b0;
    rst = 1'b0;
    seq_m = 2'd0;
    exp_q.delete();
    strobe(28'h555, 1'b1, 1'b0);
    take_word();
    chk("post_rst_count", 32'(bus.fifo_count_o), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
